volume_ctrl: RTL and testbench

VOLUME_CTRL -- requirements
Module: volume_ctrl

---
 rtl/volume_pkg.sv | 20 ++
 rtl/volume_ctrl_debounce.sv | 29 ++
 rtl/volume_ctrl.sv | 147 ++++++++++++++
 tb/tb_volume_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/volume_pkg.sv
// Shared FSM state type, volume type and volume limits for volume_ctrl.
package volume_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS     = 2'd1,
    HOLD_WAIT = 2'd2,
    REPEAT    = 2'd3
  } state_t;

  typedef logic [3:0] volume_t;

  localparam volume_t VOL_MAX_DEC = 4'd9;
  localparam volume_t VOL_MAX_HEX = 4'd15;

  function automatic logic up_allowed(input volume_t vol, input logic mode);
    return vol < (mode ? VOL_MAX_DEC : VOL_MAX_HEX);
  endfunction

endpackage

// File: rtl/volume_ctrl_debounce.sv
// Button debouncer: the level follows the raw input only after DEBOUNCE_CYCLES
// consecutive samples that disagree with the current level.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  logic [7:0] cnt_r;

  // count disagreeing samples; any agreeing sample restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 8'd0;
      level <= 1'b0;
    end else if (raw == level) begin
      cnt_r <= 8'd0;
    end else if (cnt_r == 8'(DEBOUNCE_CYCLES - 1)) begin
      cnt_r <= 8'd0;
      level <= raw;
    end else begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

endmodule

// File: rtl/volume_ctrl.sv
// Volume button controller: debounced up/down/mute buttons drive counter strobes.
// Define VOLUME_CTRL_AUTOREPEAT_EN to enable hold-to-repeat strobes.
module volume_ctrl
  import volume_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_RATE     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_mute,
  input  logic       mode,
  input  logic [3:0] volume,
  output logic       up,
  output logic       down,
  output logic       muted
);

  logic up_lvl_s;
  logic down_lvl_s;
  logic mute_lvl_s;

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk(clk), .reset(reset), .raw(btn_up), .level(up_lvl_s)
  );
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk(clk), .reset(reset), .raw(btn_down), .level(down_lvl_s)
  );
  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mute (
    .clk(clk), .reset(reset), .raw(btn_mute), .level(mute_lvl_s)
  );

  state_t state_r;
  logic   dir_up_r;
  logic   mute_prev_r;
  logic   mute_rise_s;
  logic   held_s;
  logic   allow_s;
  logic   press_ok_s;

  assign mute_rise_s = mute_lvl_s & ~mute_prev_r;
  assign held_s      = dir_up_r ? up_lvl_s : down_lvl_s;
  assign allow_s     = dir_up_r ? up_allowed(volume, mode) : (volume != 4'd0);
  // a mute edge in the strobe cycle eats that strobe
  assign press_ok_s  = ~muted & ~mute_rise_s & allow_s;

`ifdef VOLUME_CTRL_AUTOREPEAT_EN
  logic [7:0] timer_r;
  logic       hold_sup_r;
  logic       other_s;
  logic       repeat_ok_s;

  assign other_s     = dir_up_r ? down_lvl_s : up_lvl_s;
  // a hold that began while muted never strobes, even after unmuting
  assign repeat_ok_s = press_ok_s & ~hold_sup_r;
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
`endif

  // press FSM, mute state and registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      dir_up_r    <= 1'b0;
      mute_prev_r <= 1'b0;
      muted       <= 1'b0;
      up          <= 1'b0;
      down        <= 1'b0;
`ifdef VOLUME_CTRL_AUTOREPEAT_EN
      timer_r     <= 8'd0;
      hold_sup_r  <= 1'b0;
`endif
    end else begin
      mute_prev_r <= mute_lvl_s;
      up          <= 1'b0;
      down        <= 1'b0;

      if (mute_rise_s) begin
        muted <= ~muted;
      end else if (state_r == PRESS && dir_up_r && muted) begin
        muted <= 1'b0;
      end else begin
        muted <= muted;
      end

      case (state_r)
        IDLE: begin
          if (up_lvl_s ^ down_lvl_s) begin
            state_r  <= PRESS;
            dir_up_r <= up_lvl_s;
          end else begin
            state_r  <= IDLE;
          end
        end
        PRESS: begin
          up      <= dir_up_r & press_ok_s;
          down    <= ~dir_up_r & press_ok_s;
          state_r <= HOLD_WAIT;
`ifdef VOLUME_CTRL_AUTOREPEAT_EN
          hold_sup_r <= muted | mute_rise_s;
          timer_r    <= 8'd1;
`endif
        end
        HOLD_WAIT: begin
`ifdef VOLUME_CTRL_AUTOREPEAT_EN
          if (!held_s || other_s) begin
            state_r <= IDLE;
          end else if (timer_r == 8'(REPEAT_DELAY)) begin
            state_r <= REPEAT;
            timer_r <= 8'd1;
            up      <= dir_up_r & repeat_ok_s;
            down    <= ~dir_up_r & repeat_ok_s;
          end else begin
            timer_r <= timer_r + 8'd1;
          end
`else
          if (!held_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= HOLD_WAIT;
          end
`endif
        end
        REPEAT: begin
`ifdef VOLUME_CTRL_AUTOREPEAT_EN
          if (!held_s || other_s) begin
            state_r <= IDLE;
          end else if (timer_r == 8'(REPEAT_RATE)) begin
            timer_r <= 8'd1;
            up      <= dir_up_r & repeat_ok_s;
            down    <= ~dir_up_r & repeat_ok_s;
          end else begin
            timer_r <= timer_r + 8'd1;
          end
`else
          state_r <= IDLE;
`endif
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_volume_ctrl.sv
// Directed and random checks of volume_ctrl against a timestamp-based reference model.
module tb_volume_ctrl;

  localparam int DEB  = 4;
  localparam int DLY  = 16;
  localparam int RATE = 8;
`ifdef VOLUME_CTRL_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, btn_up, btn_down, btn_mute, mode;
  logic [3:0] volume;
  logic       up, down, muted;

  always #5 clk = ~clk;

  volume_ctrl #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_mute(btn_mute),
    .mode(mode), .volume(volume), .up(up), .down(down), .muted(muted)
  );

  int total = 0;
  int bad   = 0;
  int rel;
  int ups[$];
  int downs[$];

  // reference model state
  bit e_up, e_down, e_muted;
  bit lv_u, lv_d, lv_m, pm;
  bit hu[$], hd[$], hm[$];
  bit active, dir, hsup;
  int cyc = 0;
  int tp  = 0;

  function automatic bit settled(input bit q[$], input bit lvl);
    if (q.size() < DEB) return 1'b0;
    for (int i = q.size() - DEB; i < q.size(); i++)
      if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string qs(input int q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%0d ", q[i])};
    return s;
  endfunction

  task automatic model_edge();
    bit rise, due, held, other, allow, emit, press_edge;
    int k;
    if (reset) begin
      e_up = 0; e_down = 0; e_muted = 0;
      lv_u = 0; lv_d = 0; lv_m = 0; pm = 0;
      active = 0; hsup = 0;
      hu.delete(); hd.delete(); hm.delete();
      cyc++;
      return;
    end
    rise = lv_m && !pm;
    due = 0;
    press_edge = 0;
    if (active) begin
      held  = dir ? lv_u : lv_d;
      other = dir ? lv_d : lv_u;
      if (cyc == tp + 1) begin
        due = 1; press_edge = 1;
      end else if (!held || (AR && other)) begin
        active = 0;
      end else if (AR) begin
        k   = cyc - tp - 1 - DLY;
        due = (k >= 0) && (k % RATE == 0);
      end
    end else if (lv_u ^ lv_d) begin
      active = 1; tp = cyc; dir = lv_u;
    end
    allow = dir ? (volume < (mode ? 4'd9 : 4'd15)) : (volume != 4'd0);
    if (press_edge) hsup = e_muted || rise;
    emit   = due && !hsup && !e_muted && !rise && allow;
    e_up   = emit && dir;
    e_down = emit && !dir;
    if (rise) e_muted = !e_muted;
    else if (press_edge && dir && e_muted) e_muted = 0;
    pm = lv_m;
    hu.push_back(btn_up);   if (hu.size() > DEB) void'(hu.pop_front());
    hd.push_back(btn_down); if (hd.size() > DEB) void'(hd.pop_front());
    hm.push_back(btn_mute); if (hm.size() > DEB) void'(hm.pop_front());
    if (settled(hu, lv_u)) lv_u = !lv_u;
    if (settled(hd, lv_d)) lv_d = !lv_d;
    if (settled(hm, lv_m)) lv_m = !lv_m;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input string obs, input string exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed='%s' expected='%s'", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("up", up, e_up);
    chk("down", down, e_down);
    chk("muted", muted, e_muted);
    if (up === 1'b1) ups.push_back(rel);
    if (down === 1'b1) downs.push_back(rel);
    rel++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic scn();
    ups.delete(); downs.delete(); rel = 0;
  endtask

  task automatic press(input int which, input int n);
    if (which == 0) btn_up = 1'b1; else if (which == 1) btn_down = 1'b1; else btn_mute = 1'b1;
    run(n);
    btn_up = 1'b0; btn_down = 1'b0; btn_mute = 1'b0;
    run(8);
  endtask

  initial begin
    string s;
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_mute = 1'b0;
    mode = 1'b0; volume = 4'd3;
    rel = 0;
    run(2);
    chk("rst_up", up, 1'b0);
    chk("rst_down", down, 1'b0);
    chk("rst_muted", muted, 1'b0);
    reset = 1'b0;
    run(3);

    // single clean press: one pulse at cycle 5
    scn(); press(0, 12);
    chk_s("single_press", qs(ups), "5 ");

    // bouncing button never settles
    scn();
    for (int i = 0; i < 20; i++) begin
      btn_up = ((i >> 1) & 1) == 0;
      step();
    end
    btn_up = 1'b0; run(8);
    chk_s("bounce_no_strobe", qs(ups), "");
    chk("bounce_muted", muted, 1'b0);

    // long hold of down
    volume = 4'd10;
    scn(); btn_down = 1'b1; run(60);
    s = qs(downs);
    chk_s("hold_down", s, AR ? "5 21 29 37 45 53 " : "5 ");
    btn_down = 1'b0; run(10);

    // limits
    mode = 1'b1; volume = 4'd9;
    scn(); press(0, 10); chk_s("max_dec", qs(ups), "");
    volume = 4'd8;
    scn(); press(0, 10); chk_s("below_max_dec", qs(ups), "5 ");
    mode = 1'b0; volume = 4'd9;
    scn(); press(0, 10); chk_s("hex_allows_9", qs(ups), "5 ");
    volume = 4'd15;
    scn(); press(0, 10); chk_s("max_hex", qs(ups), "");
    volume = 4'd0;
    scn(); press(1, 10); chk_s("min_zero", qs(downs), "");

    // mute behaviour
    volume = 4'd5;
    press(2, 8);
    chk("mute_on", muted, 1'b1);
    scn(); press(0, 10);
    chk("up_unmutes", muted, 1'b0);
    chk_s("up_unmute_no_strobe", qs(ups), "");
    scn(); btn_up = 1'b1; btn_down = 1'b1; run(10);
    btn_up = 1'b0; btn_down = 1'b0; run(8);
    chk_s("both_no_up", qs(ups), "");
    chk_s("both_no_down", qs(downs), "");
    press(2, 8);
    chk("mute_on2", muted, 1'b1);
    scn(); press(1, 10);
    chk_s("down_ignored_muted", qs(downs), "");
    chk("down_keeps_mute", muted, 1'b1);
    press(2, 8);
    chk("mute_off", muted, 1'b0);

    // reset in the middle of a hold
    volume = 4'd3;
    btn_up = 1'b1; run(AR ? 24 : 12);
    btn_mute = 1'b1; run(8);
    chk("hold_mute", muted, 1'b1);
    reset = 1'b1; btn_mute = 1'b0;
    step();
    chk("mid_rst_up", up, 1'b0);
    chk("mid_rst_down", down, 1'b0);
    chk("mid_rst_muted", muted, 1'b0);
    reset = 1'b0;
    scn(); run(8);
    chk_s("repress_after_rst", qs(ups), "5 ");
    btn_up = 1'b0; run(10);

    // random phase against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 5) btn_up = ~btn_up;
      if ($urandom_range(0, 99) < 5) btn_down = ~btn_down;
      if ($urandom_range(0, 99) < 3) btn_mute = ~btn_mute;
      if ($urandom_range(0, 15) == 0) volume = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) mode = ~mode;
      reset = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
